top_proj_1: RTL and testbench



---
 rtl/top_proj_1_if.sv | 18 +
 rtl/top_proj_1.sv | 91 +++++++++
 tb/tb_top_proj_1.sv | 129 ++++++++++++
 3 files changed

// File: rtl/top_proj_1_if.sv
// Byte-stream bus between the upstream source, the frame processor and the
// downstream sink.
interface top_proj_1_if;
  logic [7:0] RAM_A_DATA_IN;
  logic [7:0] RAM_B_DATA_OUT;

  // Source/sink side: drives input bytes, observes the result stream.
  modport master (
    output RAM_A_DATA_IN,
    input  RAM_B_DATA_OUT
  );

  // Processor side: consumes input bytes, produces the result stream.
  modport slave (
    input  RAM_A_DATA_IN,
    output RAM_B_DATA_OUT
  );
endinterface

// File: rtl/top_proj_1.sv
// Frame-based 8-bit stream processor: 16 cycles capturing bytes into RAM A,
// 16 cycles writing symmetric pair-averages into RAM B, and 16 cycles
// streaming RAM B out. The 48-cycle frame repeats with no idle cycles.
module top_proj_1 (
  input  logic        CLK,
  input  logic        RESET,
  top_proj_1_if.slave bus
);

  typedef enum logic [1:0] {S_FILL, S_PROC, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [7:0]  r_ram_a [16];
  logic [7:0]  r_ram_b [16];
  logic [7:0]  r_out;

  logic        w_last;
  logic        w_a_we;
  logic        w_b_we;
  logic        w_drain;
  logic [3:0]  w_idx_mirror;
  logic [7:0]  w_avg;

  // Upper 8 bits of the 9-bit sum: a floor average that can never wrap.
  function automatic logic [7:0] pair_avg(input logic [7:0] a, input logic [7:0] b);
    return 8'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  assign w_last       = (r_idx == 4'd15);
  assign w_idx_mirror = ~r_idx;  // 15 - idx for a 4-bit index
  assign w_avg        = pair_avg(r_ram_a[r_idx], r_ram_a[w_idx_mirror]);

  // State register: reset always restarts at the beginning of FILL.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_FILL;
    else        r_state <= w_next;
  end

  // Next-state logic: each phase lasts exactly 16 cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL:  if (w_last) w_next = S_PROC;
      S_PROC:  if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_last) w_next = S_FILL;
      default: w_next = S_FILL;
    endcase
  end

  // Per-state strobes selecting which array is written or read.
  always_comb begin
    w_a_we  = 1'b0;
    w_b_we  = 1'b0;
    w_drain = 1'b0;
    case (r_state)
      S_FILL:  w_a_we  = 1'b1;
      S_PROC:  w_b_we  = 1'b1;
      S_DRAIN: w_drain = 1'b1;
      default: ;
    endcase
  end

  // Index counter shared by all three phases; returns to 0 at each phase end.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      r_idx <= 4'd0;
    else if (w_last) r_idx <= 4'd0;
    else             r_idx <= r_idx + 4'd1;
  end

  // RAM A capture during FILL; contents are not reset.
  always_ff @(posedge CLK) begin
    if (w_a_we) r_ram_a[r_idx] <= bus.RAM_A_DATA_IN;
  end

  // RAM B pair-average write during PROC; reads only RAM A, so no hazard.
  always_ff @(posedge CLK) begin
    if (w_b_we) r_ram_b[r_idx] <= w_avg;
  end

  // Registered output: RAM B word during DRAIN, zero in every other state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)       r_out <= 8'h00;
    else if (w_drain) r_out <= r_ram_b[r_idx];
    else              r_out <= 8'h00;
  end

  assign bus.RAM_B_DATA_OUT = r_out;

endmodule

// File: tb/tb_top_proj_1.sv
// Directed bench for the frame processor: reset behaviour, ramp, carry,
// asymmetric/rounding pattern, mid-frame resets and random frames.
module tb_top_proj_1;

  logic CLK;
  logic RESET;
  top_proj_1_if bus ();

  top_proj_1 dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] frame_in [16];
  logic [7:0] exp_out  [16];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Runs frame edges 0..n_edges-1 from frame_in, checking output after each edge.
  task automatic run_frame(input string tag, input int n_edges);
    for (int e = 0; e < n_edges; e++) begin
      if (e < 16) bus.RAM_A_DATA_IN = frame_in[e];
      else        bus.RAM_A_DATA_IN = 8'($urandom);
      @(posedge CLK);
      #1;
      if (e < 32) check($sformatf("%s_idle_e%0d", tag, e), bus.RAM_B_DATA_OUT, 8'h00);
      else        check($sformatf("%s_drain_k%0d", tag, e - 32), bus.RAM_B_DATA_OUT, exp_out[e - 32]);
    end
  endtask

  // Asserts reset away from the clock edge, checks the asynchronous clear,
  // holds it 3 cycles with random input, then releases mid-cycle.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check($sformatf("%s_async", tag), bus.RAM_B_DATA_OUT, 8'h00);
    for (int c = 0; c < 3; c++) begin
      bus.RAM_A_DATA_IN = 8'($urandom);
      @(posedge CLK);
      #1;
      check($sformatf("%s_hold%0d", tag, c), bus.RAM_B_DATA_OUT, 8'h00);
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 16; k++) begin
      frame_in[k] = 8'(16 * k);
      exp_out[k]  = 8'h78;
    end
  endtask

  initial begin
    RESET = 1'b0;
    bus.RAM_A_DATA_IN = 8'h00;
    #2;
    check("por_async", bus.RAM_B_DATA_OUT, 8'h00);

    // Reset check, then ramp frame: 0x78 everywhere in DRAIN
    do_reset("rst0");
    load_ramp();
    run_frame("ramp", 48);

    // Carry: 0xFF + 0xFF must not wrap; first FILL edge also checks the
    // return to 0x00 after B[15] is held one cycle
    for (int k = 0; k < 16; k++) begin
      frame_in[k] = 8'hFF;
      exp_out[k]  = 8'hFF;
    end
    run_frame("carry", 48);

    // Asymmetric / rounding pattern, hand-computed results
    for (int k = 0; k < 16; k++) begin
      frame_in[k] = 8'h00;
      exp_out[k]  = 8'h00;
    end
    frame_in[0]  = 8'h01; frame_in[15] = 8'h02;  // (1+2)>>1  = 1
    frame_in[1]  = 8'h10; frame_in[14] = 8'h31;  // (16+49)>>1 = 32
    exp_out[0]   = 8'h01; exp_out[15]  = 8'h01;
    exp_out[1]   = 8'h20; exp_out[14]  = 8'h20;
    run_frame("asym", 48);

    // Mid-frame reset during PROC (after frame edge 20), then ramp frame
    for (int k = 0; k < 16; k++) frame_in[k] = 8'($urandom);
    run_frame("pre_proc_rst", 21);
    do_reset("rst_proc");
    load_ramp();
    run_frame("ramp_after_proc_rst", 48);

    // Reset during DRAIN while output is non-zero must clear it at once
    run_frame("pre_drain_rst", 36);
    do_reset("rst_drain");
    load_ramp();
    run_frame("ramp_after_drain_rst", 48);

    // Five back-to-back random frames against a pair-average model
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 16; k++) frame_in[k] = 8'($urandom);
      for (int k = 0; k < 16; k++)
        exp_out[k] = 8'((int'(frame_in[k]) + int'(frame_in[15 - k])) / 2);
      run_frame($sformatf("rand%0d", f), 48);
    end

    // Output returns to 0x00 one cycle after the final B[15]
    bus.RAM_A_DATA_IN = 8'h00;
    @(posedge CLK);
    #1;
    check("post_drain_zero", bus.RAM_B_DATA_OUT, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
